// File: rtl/pwm3_deadtime.sv
// Three-phase PWM with double-buffered duty/dead-time and per-phase dead-time FSMs.
// Gate outputs are registered and decoded from each phase's next state.
//
// state   | meaning
// LOW_ON  | low-side gate on, high-side off
// HIGH_ON | high-side gate on, low-side off
// DEAD    | both gates off, counting down dtcnt before entering the target ON state
module pwm3_deadtime #(
  parameter int CW      = 5,
  parameter int CNT_TOP = 19,
  parameter int DTW     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  cnt,
  input  logic           en,
  input  logic [CW-1:0]  duty_a,
  input  logic [CW-1:0]  duty_b,
  input  logic [CW-1:0]  duty_c,
  input  logic [DTW-1:0] dt,
  input  logic           duty_vld,
  output logic           ah,
  output logic           al,
  output logic           bh,
  output logic           bl,
  output logic           ch,
  output logic           cl,
  output logic           prd_load
);

  typedef enum logic [1:0] {LOW_ON, HIGH_ON, DEAD} ph_state_t;

  localparam logic [CW-1:0] TOP = CW'(CNT_TOP);

  logic [CW-1:0]  duty_in  [3];
  logic [CW-1:0]  sh_duty  [3];
  logic [CW-1:0]  act_duty [3];
  logic [DTW-1:0] sh_dt, act_dt, dt_m1;
  logic           at_top;
  logic [2:0]     raw;

  ph_state_t      st_q  [3];
  ph_state_t      st_n  [3];
  logic [2:0]     tgt_q, tgt_n;
  logic [DTW-1:0] dtc_q [3];
  logic [DTW-1:0] dtc_n [3];
  logic [2:0]     gh_q, gl_q;

  assign duty_in[0] = duty_a;
  assign duty_in[1] = duty_b;
  assign duty_in[2] = duty_c;
  assign at_top     = (cnt == TOP);
  assign dt_m1      = (act_dt == '0) ? '0 : act_dt - DTW'(1);

  // A strobe landing on the wrap edge bypasses the shadow so it takes effect at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sh_duty[i]  <= '0;
        act_duty[i] <= '0;
      end
      sh_dt    <= '0;
      act_dt   <= '0;
      prd_load <= 1'b0;
    end else begin
      if (duty_vld) begin
        for (int i = 0; i < 3; i++) sh_duty[i] <= duty_in[i];
        sh_dt <= dt;
      end
      if (at_top) begin
        for (int i = 0; i < 3; i++) act_duty[i] <= duty_vld ? duty_in[i] : sh_duty[i];
        act_dt <= duty_vld ? dt : sh_dt;
      end
      prd_load <= at_top;
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < 3; i++) raw[i] = (cnt < act_duty[i]);
  end

  always_comb begin
    tgt_n = tgt_q;
    for (int i = 0; i < 3; i++) begin
      st_n[i]  = st_q[i];
      dtc_n[i] = dtc_q[i];
      if (!en) begin
        st_n[i]  = DEAD;
        tgt_n[i] = raw[i];
        dtc_n[i] = dt_m1;
      end else begin
        case (st_q[i])
          LOW_ON, HIGH_ON: begin
            if (raw[i] != (st_q[i] == HIGH_ON)) begin
              tgt_n[i] = raw[i];
              dtc_n[i] = dt_m1;
              if (act_dt == '0) st_n[i] = raw[i] ? HIGH_ON : LOW_ON;
              else              st_n[i] = DEAD;
            end
          end
          DEAD: begin
            if (raw[i] != tgt_q[i]) begin
              tgt_n[i] = raw[i];
              dtc_n[i] = dt_m1;
              if (act_dt == '0) st_n[i] = raw[i] ? HIGH_ON : LOW_ON;
            end else if (dtc_q[i] == '0) begin
              st_n[i] = tgt_q[i] ? HIGH_ON : LOW_ON;
            end else begin
              dtc_n[i] = dtc_q[i] - DTW'(1);
            end
          end
          default: st_n[i] = DEAD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= DEAD;
        dtc_q[i] <= '0;
      end
      tgt_q <= '0;
      gh_q  <= '0;
      gl_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_n[i];
        dtc_q[i] <= dtc_n[i];
        gh_q[i]  <= (st_n[i] == HIGH_ON);
        gl_q[i]  <= (st_n[i] == LOW_ON);
      end
      tgt_q <= tgt_n;
    end
  end

  assign ah = gh_q[0];
  assign al = gl_q[0];
  assign bh = gh_q[1];
  assign bl = gl_q[1];
  assign ch = gh_q[2];
  assign cl = gl_q[2];

endmodule

// File: tb/tb_pwm3_deadtime.sv
// Directed bench for pwm3_deadtime: buffering, compare, dead time, enable and reset.
module tb_pwm3_deadtime;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cnt = '0;
  logic       en = 1'b0;
  logic [4:0] duty_a = '0, duty_b = '0, duty_c = '0;
  logic [3:0] dt = '0;
  logic       duty_vld = 1'b0;
  logic       ah, al, bh, bl, ch, cl, prd_load;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int e = 0;

  pwm3_deadtime dut (
    .clk(clk), .rst(rst), .cnt(cnt), .en(en),
    .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c), .dt(dt), .duty_vld(duty_vld),
    .ah(ah), .al(al), .bh(bh), .bl(bl), .ch(ch), .cl(cl), .prd_load(prd_load)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if ((ah & al) === 1'b1 || (bh & bl) === 1'b1 || (ch & cl) === 1'b1) overlap++;

  // One clock: e holds the carrier value sampled by the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
    e = int'(cnt);
    cnt = (cnt == 5'd19) ? 5'd0 : cnt + 5'd1;
  endtask

  task automatic run_to(input int c);
    while (int'(cnt) != c) tick();
  endtask

  task automatic strobe();
    duty_vld = 1'b1;
    tick();
    duty_vld = 1'b0;
  endtask

  task automatic test_reset();
    int on;
    int pl;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({ah, al, bh, bl, ch, cl, prd_load} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 0000000", {ah, al, bh, bl, ch, cl, prd_load});
      end
    end
    rst = 1'b0;
    on = 0;
    pl = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if ({ah, al, bh, bl, ch, cl} !== 6'b0) on++;
      if (prd_load === 1'b1) pl++;
    end
    checks++;
    if (on != 0) begin
      errors++;
      $display("FAIL disabled_gates: %0d cycles with a gate on, want 0", on);
    end
    checks++;
    if (pl != 1) begin
      errors++;
      $display("FAIL prd_load_count: got %0d pulses, want 1", pl);
    end
  endtask

  task automatic test_basic_deadtime();
    duty_a = 5'd10; duty_b = 5'd0; duty_c = 5'd0; dt = 4'd2;
    strobe();
    en = 1'b1;
    run_to(19);
    tick();
    repeat (20) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (ah !== (e >= 2 && e <= 9)) begin
        errors++;
        $display("FAIL a_high cnt=%0d: got %b want %b", e, ah, (e >= 2 && e <= 9));
      end
      checks++;
      if (al !== (e >= 12 && e <= 19)) begin
        errors++;
        $display("FAIL a_low cnt=%0d: got %b want %b", e, al, (e >= 12 && e <= 19));
      end
      checks++;
      if (bl !== 1'b1 || bh !== 1'b0) begin
        errors++;
        $display("FAIL b_zero_duty cnt=%0d: got bh=%b bl=%b want bh=0 bl=1", e, bh, bl);
      end
    end
  endtask

  task automatic test_full_duty(input logic [4:0] d);
    int nbh;
    int nbl;
    duty_b = d;
    strobe();
    run_to(19);
    tick();
    repeat (20) tick();
    nbh = 0;
    nbl = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bh === 1'b1) nbh++;
      if (bl === 1'b1) nbl++;
    end
    checks++;
    if (nbh != 20 || nbl != 0) begin
      errors++;
      $display("FAIL b_full_duty d=%0d: bh %0d bl %0d cycles, want 20 and 0", d, nbh, nbl);
    end
  endtask

  task automatic test_zero_deadtime();
    duty_c = 5'd5; dt = 4'd0;
    strobe();
    run_to(19);
    tick();
    repeat (20) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (ch !== (e < 5) || cl !== (e >= 5)) begin
        errors++;
        $display("FAIL c_direct cnt=%0d: got ch=%b cl=%b want ch=%b cl=%b", e, ch, cl, (e < 5), (e >= 5));
      end
    end
  endtask

  task automatic test_buffering();
    run_to(7);
    duty_a = 5'd4;
    strobe();
    checks++;
    if (ah !== 1'b1) begin
      errors++;
      $display("FAIL mid_strobe_edge: got ah=%b want 1", ah);
    end
    while (e != 19) begin
      tick();
      checks++;
      if (ah !== (e < 10)) begin
        errors++;
        $display("FAIL old_period cnt=%0d: got ah=%b want %b", e, ah, (e < 10));
      end
    end
    checks++;
    if (prd_load !== 1'b1) begin
      errors++;
      $display("FAIL prd_load_pulse: got %b want 1", prd_load);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (ah !== (e < 4)) begin
        errors++;
        $display("FAIL new_period cnt=%0d: got ah=%b want %b", e, ah, (e < 4));
      end
      if (e == 0) begin
        checks++;
        if (prd_load !== 1'b0) begin
          errors++;
          $display("FAIL prd_load_width: got %b want 0", prd_load);
        end
      end
    end
    run_to(19);
    duty_a = 5'd12;
    strobe();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (ah !== (e < 12)) begin
        errors++;
        $display("FAIL top_strobe cnt=%0d: got ah=%b want %b", e, ah, (e < 12));
      end
    end
  endtask

  task automatic test_enable();
    run_to(19);
    duty_a = 5'd10; dt = 4'd2;
    strobe();
    run_to(4);
    tick();
    checks++;
    if (ah !== 1'b1) begin
      errors++;
      $display("FAIL pre_disable: got ah=%b want 1", ah);
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({ah, al, bh, bl, ch, cl} !== 6'b0) begin
        errors++;
        $display("FAIL disable_gates cnt=%0d: got %b want 000000", e, {ah, al, bh, bl, ch, cl});
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({ah, al, bh, bl, ch, cl} !== 6'b0) begin
      errors++;
      $display("FAIL reenable_dead: got %b want 000000", {ah, al, bh, bl, ch, cl});
    end
    tick();
    checks++;
    if ({ah, al, bh, bl, ch, cl} !== 6'b101001) begin
      errors++;
      $display("FAIL reenable_on: got %b want 101001", {ah, al, bh, bl, ch, cl});
    end
  endtask

  task automatic test_reset_mid_dead();
    int nah;
    int nal;
    run_to(19);
    dt = 4'd15;
    strobe();
    run_to(5);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({ah, al, bh, bl, ch, cl, prd_load} !== 7'b0) begin
        errors++;
        $display("FAIL mid_reset: got %b want 0000000", {ah, al, bh, bl, ch, cl, prd_load});
      end
    end
    rst = 1'b0;
    en = 1'b0;
    run_to(19);
    tick();
    checks++;
    if (prd_load !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_load: got %b want 1", prd_load);
    end
    en = 1'b1;
    nah = 0;
    nal = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ah === 1'b1) nah++;
      if (al === 1'b1) nal++;
    end
    checks++;
    if (nah != 0 || nal != 20) begin
      errors++;
      $display("FAIL cleared_regs: ah %0d al %0d cycles, want 0 and 20", nah, nal);
    end
  endtask

  initial begin
    test_reset();
    test_basic_deadtime();
    test_full_duty(5'd20);
    test_full_duty(5'd31);
    test_zero_deadtime();
    test_buffering();
    test_enable();
    test_reset_mid_dead();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL shoot_through: %0d overlap cycles, want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
